oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/oam_dma_ctrl_if.sv | 30 +++
 rtl/oam_dma_ctrl.sv | 110 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side bus and DMA bus-master signals bundled for the OAM DMA controller.
interface oam_dma_ctrl_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic              cpu_clk_en;
  logic              cpu_cyc_par;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              cpu_sus;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_re;
  logic              dma_we;
  logic [DATA_W-1:0] dma_wr_data;
  logic              dma_done;

  // System side: drives CPU bus activity and memory read data.
  modport master (
    output cpu_clk_en, cpu_cyc_par, cpu_addr, cpu_we, cpu_wr_data, mem_rd_data,
    input  cpu_sus, dma_addr, dma_re, dma_we, dma_wr_data, dma_done
  );

  // DMA controller side.
  modport slave (
    input  cpu_clk_en, cpu_cyc_par, cpu_addr, cpu_we, cpu_wr_data, mem_rd_data,
    output cpu_sus, dma_addr, dma_re, dma_we, dma_wr_data, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies one 256-byte CPU page into PPU OAMDATA while
// holding the CPU suspended. All sequencing advances on CPU-cycle ticks only.
module oam_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input logic           clock,
  input logic           reset,
  oam_dma_ctrl_if.slave bus
);
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] page_q, page_d;
  logic [DATA_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sus_q, sus_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  // Next-state, datapath and next-output computation; outputs derive from the next state.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    data_d  = data_q;
    done_d  = 1'b0;

    if (bus.cpu_clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.cpu_we && (bus.cpu_addr == TRIG_ADDR)) begin
            page_d  = bus.cpu_wr_data;
            index_d = '0;
            state_d = S_HALT;
          end
        end
        S_HALT:  state_d = bus.cpu_cyc_par ? S_ALIGN : S_READ;
        S_ALIGN: state_d = S_READ;
        S_READ: begin
          data_d  = bus.mem_rd_data;
          state_d = S_WRITE;
        end
        S_WRITE: begin
          // Index wraps within the page; it never carries into page.
          index_d = index_q + DATA_W'(1);
          if (index_q == {DATA_W{1'b1}}) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    sus_d  = (state_d != S_IDLE);
    re_d   = (state_d == S_READ);
    we_d   = (state_d == S_WRITE);
    case (state_d)
      S_READ:  addr_d = {page_d, index_d};
      S_WRITE: addr_d = DEST_ADDR;
      default: addr_d = '0;
    endcase
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
      sus_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      data_q  <= data_d;
      sus_q   <= sus_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign bus.cpu_sus     = sus_q;
  assign bus.dma_re      = re_q;
  assign bus.dma_we      = we_q;
  assign bus.dma_addr    = addr_q;
  assign bus.dma_wr_data = data_q;
  assign bus.dma_done    = done_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: idle-bus vector table plus full transfers,
// alignment, page wrap, mid-transfer reset and stray trigger writes.
module tb_oam_dma_ctrl;
  logic clock;
  logic reset;
  logic pat_ff;
  int   n_checks;
  int   n_pass;
  int   sus_cnt;
  int   done_cnt;
  logic [7:0] exp_last;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl #(
    .TRIG_ADDR(16'h4014),
    .DEST_ADDR(16'h2004)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents as a function of address.
  function automatic logic [7:0] mem_byte(input logic [15:0] a, input logic sel);
    if (sel) return a[7:0] ^ 8'h5A;
    return (a[7:0] + (a[15:8] * 8'd7)) ^ 8'hC3;
  endfunction

  assign bus.mem_rd_data = mem_byte(bus.dma_addr, pat_ff);

  // Count CPU cycles spent suspended and dma_done pulses.
  always @(posedge clock) if (bus.cpu_clk_en && bus.cpu_sus) sus_cnt <= sus_cnt + 1;
  always @(negedge clock) if (bus.dma_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // One CPU cycle: two idle master clocks, then a one-clock cpu_clk_en pulse.
  task automatic tick(input logic en, input logic we, input logic [15:0] a,
                      input logic [7:0] d, input logic p);
    repeat (2) @(posedge clock);
    @(negedge clock);
    bus.cpu_clk_en  = en;
    bus.cpu_we      = we;
    bus.cpu_addr    = a;
    bus.cpu_wr_data = d;
    bus.cpu_cyc_par = p;
    @(posedge clock);
    #1;
    bus.cpu_clk_en = 1'b0;
    bus.cpu_we     = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] page, input logic par, input logic stray);
    logic [15:0] ra;
    sus_cnt  = 0;
    done_cnt = 0;
    tick(1'b1, 1'b1, 16'h4014, page, 1'b0);
    chk("halt_sus", 16'(bus.cpu_sus), 16'd1);
    chk("halt_re", 16'(bus.dma_re), 16'd0);
    chk("halt_we", 16'(bus.dma_we), 16'd0);
    chk("halt_addr", bus.dma_addr, 16'h0000);
    tick(1'b1, 1'b0, 16'h0000, 8'h00, par);
    if (par) begin
      chk("align_sus", 16'(bus.cpu_sus), 16'd1);
      chk("align_re", 16'(bus.dma_re), 16'd0);
      chk("align_addr", bus.dma_addr, 16'h0000);
      tick(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    end
    for (int i = 0; i < 256; i++) begin
      ra = {page, 8'(i)};
      chk($sformatf("rd_addr[%0d]", i), bus.dma_addr, ra);
      chk($sformatf("rd_re[%0d]", i), 16'(bus.dma_re), 16'd1);
      chk($sformatf("rd_we[%0d]", i), 16'(bus.dma_we), 16'd0);
      chk($sformatf("rd_sus[%0d]", i), 16'(bus.cpu_sus), 16'd1);
      chk($sformatf("rd_hold_data[%0d]", i), 16'(bus.dma_wr_data), 16'(exp_last));
      chk($sformatf("rd_done[%0d]", i), 16'(bus.dma_done), 16'd0);
      if (i == 128) begin
        @(posedge clock);
        #1;
        chk("gap_hold_addr", bus.dma_addr, ra);
        chk("gap_hold_re", 16'(bus.dma_re), 16'd1);
      end
      tick(1'b1, stray && (i == 16), 16'h4014, 8'h77, 1'(i));
      exp_last = mem_byte(ra, pat_ff);
      chk($sformatf("wr_addr[%0d]", i), bus.dma_addr, 16'h2004);
      chk($sformatf("wr_we[%0d]", i), 16'(bus.dma_we), 16'd1);
      chk($sformatf("wr_re[%0d]", i), 16'(bus.dma_re), 16'd0);
      chk($sformatf("wr_data[%0d]", i), 16'(bus.dma_wr_data), 16'(exp_last));
      chk($sformatf("wr_done[%0d]", i), 16'(bus.dma_done), 16'd0);
      tick(1'b1, stray && (i == 16), 16'h4014, 8'h33, ~1'(i));
    end
    chk("end_done", 16'(bus.dma_done), 16'd1);
    chk("end_sus", 16'(bus.cpu_sus), 16'd0);
    chk("end_re", 16'(bus.dma_re), 16'd0);
    chk("end_we", 16'(bus.dma_we), 16'd0);
    chk("end_addr", bus.dma_addr, 16'h0000);
    chk("end_data", 16'(bus.dma_wr_data), 16'(exp_last));
    @(posedge clock);
    #1;
    chk("done_drop", 16'(bus.dma_done), 16'd0);
    chk("done_count", 16'(done_cnt), 16'd1);
    chk("sus_cycles", 16'(sus_cnt), par ? 16'd514 : 16'd513);
  endtask

  typedef struct {
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    string       name;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h4014, 8'h02, "read_trig"};
    vecs[1] = '{1'b1, 1'b1, 16'h4013, 8'h02, "wr_4013"};
    vecs[2] = '{1'b1, 1'b1, 16'h4015, 8'h02, "wr_4015"};
    vecs[3] = '{1'b1, 1'b1, 16'h2014, 8'h02, "wr_2014"};
    vecs[4] = '{1'b1, 1'b1, 16'h0014, 8'h02, "wr_0014"};
    vecs[5] = '{1'b0, 1'b1, 16'h4014, 8'h02, "trig_no_tick"};

    n_checks = 0;
    n_pass   = 0;
    sus_cnt  = 0;
    done_cnt = 0;
    exp_last = 8'h00;
    pat_ff   = 1'b0;
    reset    = 1'b1;
    bus.cpu_clk_en  = 1'b0;
    bus.cpu_cyc_par = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_we      = 1'b0;
    bus.cpu_wr_data = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_sus", 16'(bus.cpu_sus), 16'd0);
    chk("rst_re", 16'(bus.dma_re), 16'd0);
    chk("rst_we", 16'(bus.dma_we), 16'd0);
    chk("rst_addr", bus.dma_addr, 16'h0000);
    chk("rst_data", 16'(bus.dma_wr_data), 16'd0);
    chk("rst_done", 16'(bus.dma_done), 16'd0);

    // Idle-bus vectors: none of these may start a transfer.
    for (int k = 0; k < 6; k++) begin
      tick(vecs[k].en, vecs[k].we, vecs[k].addr, vecs[k].wdata, 1'b0);
      chk({vecs[k].name, "_sus"}, 16'(bus.cpu_sus), 16'd0);
      chk({vecs[k].name, "_re"}, 16'(bus.dma_re), 16'd0);
      chk({vecs[k].name, "_we"}, 16'(bus.dma_we), 16'd0);
      chk({vecs[k].name, "_addr"}, bus.dma_addr, 16'h0000);
    end

    // Even-parity HALT with a stray trigger write mid-transfer.
    run_xfer(8'h02, 1'b0, 1'b1);
    // Odd-parity HALT inserts one ALIGN cycle.
    run_xfer(8'h02, 1'b1, 1'b0);
    // Top page stays within $FF00-$FFFF.
    pat_ff = 1'b1;
    run_xfer(8'hFF, 1'b0, 1'b0);
    pat_ff = 1'b0;

    // Reset during the WRITE of index 8'h40.
    tick(1'b1, 1'b1, 16'h4014, 8'h05, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    repeat (129) tick(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
    chk("pre_rst_we", 16'(bus.dma_we), 16'd1);
    chk("pre_rst_data", 16'(bus.dma_wr_data), 16'(mem_byte(16'h0540, 1'b0)));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_sus", 16'(bus.cpu_sus), 16'd0);
    chk("arst_re", 16'(bus.dma_re), 16'd0);
    chk("arst_we", 16'(bus.dma_we), 16'd0);
    chk("arst_addr", bus.dma_addr, 16'h0000);
    chk("arst_data", 16'(bus.dma_wr_data), 16'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_last = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 16'h0000, 8'h00, 1'(k));
      chk("post_rst_sus", 16'(bus.cpu_sus), 16'd0);
      chk("post_rst_re", 16'(bus.dma_re), 16'd0);
      chk("post_rst_we", 16'(bus.dma_we), 16'd0);
    end
    run_xfer(8'h03, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
